// File: rtl/magic_button_ctrl_if.sv
// Signal bundle between the front panel / keyboard / NMI side and the magic button controller.
// The master drives the raw inputs; the slave is the controller itself.
interface magic_button_ctrl_if;
    logic btn_n;
    logic hotkey;
    logic n_int;
    logic magic_mode;
    logic magic_button;
    logic reset_req;
    logic req_timeout;
    logic btn_pressed;

    modport master (
        output btn_n, hotkey, n_int, magic_mode,
        input  magic_button, reset_req, req_timeout, btn_pressed
    );

    modport slave (
        input  btn_n, hotkey, n_int, magic_mode,
        output magic_button, reset_req, req_timeout, btn_pressed
    );
endinterface

// File: rtl/magic_button_ctrl.sv
// Magic button controller: debounces the front-panel button, separates short and long presses,
// and issues a magic request that holds until acknowledged by magic_mode or timed out on frame edges.
module magic_button_ctrl #(
    parameter int DEBOUNCE_CYCLES    = 140000,
    parameter int LONG_FRAMES        = 100,
    parameter int REQ_TIMEOUT_FRAMES = 10
) (
    input  logic               clk28,
    input  logic               rst_n,
    magic_button_ctrl_if.slave bus
);
    localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FRAME_MAX = (LONG_FRAMES > REQ_TIMEOUT_FRAMES) ? LONG_FRAMES : REQ_TIMEOUT_FRAMES;
    localparam int FR_W      = $clog2(FRAME_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] LONG_LAST = FR_W'(LONG_FRAMES - 1);
    localparam logic [FR_W-1:0] TMO_LAST  = FR_W'(REQ_TIMEOUT_FRAMES - 1);
    localparam logic [FR_W-1:0] FR_SAT    = '1;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG,
        REQUEST,
        WAIT_EXIT
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_pressed_q, btn_pressed_d;
    logic            btn_prev_q, btn_prev_d;
    logic            nint_q, nint_d;
    logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            magic_button_q, magic_button_d;
    logic            reset_req_q, reset_req_d;
    logic            req_timeout_q, req_timeout_d;

    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic frame_edge;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        sync1_d        = bus.btn_n;
        sync2_d        = sync1_q;
        btn_level      = ~sync2_q;
        btn_pressed_d  = btn_pressed_q;
        db_cnt_d       = db_cnt_q;
        btn_prev_d     = btn_pressed_q;
        nint_d         = bus.n_int;
        state_d        = state_q;
        reset_req_d    = 1'b0;
        req_timeout_d  = 1'b0;

        if (btn_level == btn_pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_pressed_d = ~btn_pressed_q;
            db_cnt_d      = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        btn_rise   = btn_pressed_q & ~btn_prev_q;
        btn_fall   = ~btn_pressed_q & btn_prev_q;
        frame_edge = nint_q & ~bus.n_int;

        case (state_q)
            IDLE: begin
                if (bus.magic_mode)  state_d = WAIT_EXIT;
                else if (btn_rise)   state_d = HELD;
                else if (bus.hotkey) state_d = REQUEST;
            end
            HELD: begin
                if (btn_fall) begin
                    state_d = REQUEST;
                end else if (frame_edge && frame_cnt_q == LONG_LAST) begin
                    state_d     = LONG;
                    reset_req_d = 1'b1;
                end
            end
            LONG: begin
                if (btn_fall) state_d = IDLE;
            end
            REQUEST: begin
                // Acknowledge outranks a timeout landing on the same frame edge.
                if (bus.magic_mode) begin
                    state_d = WAIT_EXIT;
                end else if (frame_edge && frame_cnt_q == TMO_LAST) begin
                    state_d       = IDLE;
                    req_timeout_d = 1'b1;
                end
            end
            WAIT_EXIT: begin
                if (!bus.magic_mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            frame_cnt_d = '0;
        else if (frame_edge && frame_cnt_q != FR_SAT)
            frame_cnt_d = frame_cnt_q + 1'b1;
        else
            frame_cnt_d = frame_cnt_q;

        magic_button_d = (state_d == REQUEST);
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than listed as an edge.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            db_cnt_q       <= '0;
            btn_pressed_q  <= 1'b0;
            btn_prev_q     <= 1'b0;
            nint_q         <= 1'b1;
            frame_cnt_q    <= '0;
            magic_button_q <= 1'b0;
            reset_req_q    <= 1'b0;
            req_timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, order-independent.
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_cnt_q       <= db_cnt_d;
            btn_pressed_q  <= btn_pressed_d;
            btn_prev_q     <= btn_prev_d;
            nint_q         <= nint_d;
            frame_cnt_q    <= frame_cnt_d;
            magic_button_q <= magic_button_d;
            reset_req_q    <= reset_req_d;
            req_timeout_q  <= req_timeout_d;
        end
    end

    assign bus.magic_button = magic_button_q;
    assign bus.reset_req    = reset_req_q;
    assign bus.req_timeout  = req_timeout_q;
    assign bus.btn_pressed  = btn_pressed_q;
endmodule

// File: tb/tb_magic_button_ctrl.sv
// Scoreboard bench for magic_button_ctrl: each stimulus step queues the output events it should cause
// (kind and clock cycle); a negedge monitor pops and compares every event the DUT produces.
module tb_magic_button_ctrl;
    typedef enum int {
        EV_NONE = 0,
        EV_BP_RISE,
        EV_BP_FALL,
        EV_MB_RISE,
        EV_MB_FALL,
        EV_RR,
        EV_TO
    } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
    } exp_t;

    logic clk28 = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    logic p_bp = 1'b0, p_mb = 1'b0, p_rr = 1'b0, p_to = 1'b0;
    exp_t sb[$];

    magic_button_ctrl_if bus_if ();

    magic_button_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_FRAMES       (3),
        .REQ_TIMEOUT_FRAMES(2)
    ) dut (
        .clk28(clk28),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk28 = ~clk28;

    always @(posedge clk28) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic got(input ev_e k);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected_%s", k.name()), k, EV_NONE);
        end else begin
            e = sb.pop_front();
            check($sformatf("event_kind_%s", e.kind.name()), k, e.kind);
            check($sformatf("event_cycle_%s", e.kind.name()), cyc, e.cyc);
        end
    endtask

    always @(negedge clk28) begin
        if (mon_en) begin
            if (bus_if.btn_pressed && !p_bp)  got(EV_BP_RISE);
            if (!bus_if.btn_pressed && p_bp)  got(EV_BP_FALL);
            if (bus_if.magic_button && !p_mb) got(EV_MB_RISE);
            if (!bus_if.magic_button && p_mb) got(EV_MB_FALL);
            if (bus_if.reset_req) begin
                got(EV_RR);
                check("reset_req_width", p_rr, 1'b0);
            end
            if (bus_if.req_timeout) begin
                got(EV_TO);
                check("req_timeout_width", p_to, 1'b0);
            end
        end
        p_bp = bus_if.btn_pressed;
        p_mb = bus_if.magic_button;
        p_rr = bus_if.reset_req;
        p_to = bus_if.req_timeout;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk28);
            #2;
        end
    endtask

    task automatic expect_ev(input ev_e k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic frame();
        bus_if.n_int = 1'b0;
        step();
        bus_if.n_int = 1'b1;
        step();
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_magic_button"}, bus_if.magic_button, 1'b0);
        check({tag, "_reset_req"},    bus_if.reset_req,    1'b0);
        check({tag, "_req_timeout"},  bus_if.req_timeout,  1'b0);
        check({tag, "_btn_pressed"},  bus_if.btn_pressed,  1'b0);
    endtask

    initial begin
        bus_if.btn_n      = 1'b1;
        bus_if.hotkey     = 1'b0;
        bus_if.n_int      = 1'b1;
        bus_if.magic_mode = 1'b0;
        rst_n             = 1'b0;
        step(3);
        rst_n = 1'b1;
        check_all_low("reset");
        mon_en = 1'b1;
        step(2);

        // Bounced press, short press released after one frame edge, then acknowledge.
        bus_if.btn_n = 1'b0;
        step(2);
        bus_if.btn_n = 1'b1;
        step();
        bus_if.btn_n = 1'b0;
        expect_ev(EV_BP_RISE, cyc + 6);
        step(5);
        check("debounce_not_yet", bus_if.btn_pressed, 1'b0);
        step(3);
        frame();
        bus_if.btn_n = 1'b1;
        expect_ev(EV_BP_FALL, cyc + 6);
        expect_ev(EV_MB_RISE, cyc + 7);
        step(8);
        check("short_press_request", bus_if.magic_button, 1'b1);
        bus_if.magic_mode = 1'b1;
        expect_ev(EV_MB_FALL, cyc + 1);
        step();
        check("ack_drops_request", bus_if.magic_button, 1'b0);
        step(2);
        bus_if.magic_mode = 1'b0;
        step(2);

        // Long press: one reset_req pulse on the 3rd edge, nothing on further edges.
        bus_if.btn_n = 1'b0;
        expect_ev(EV_BP_RISE, cyc + 6);
        step(8);
        frame();
        frame();
        bus_if.n_int = 1'b0;
        expect_ev(EV_RR, cyc + 1);
        step();
        bus_if.n_int = 1'b1;
        check("long_reset_req", bus_if.reset_req, 1'b1);
        step();
        repeat (5) frame();
        check("long_no_request", bus_if.magic_button, 1'b0);
        bus_if.btn_n = 1'b1;
        expect_ev(EV_BP_FALL, cyc + 6);
        step(8);

        // Hotkey request left unacknowledged times out on the 2nd frame edge.
        bus_if.hotkey = 1'b1;
        expect_ev(EV_MB_RISE, cyc + 1);
        step();
        bus_if.hotkey = 1'b0;
        check("hotkey_request", bus_if.magic_button, 1'b1);
        step();
        frame();
        bus_if.n_int = 1'b0;
        expect_ev(EV_MB_FALL, cyc + 1);
        expect_ev(EV_TO, cyc + 1);
        step();
        bus_if.n_int = 1'b1;
        check("timeout_pulse", bus_if.req_timeout, 1'b1);
        check("timeout_drops_request", bus_if.magic_button, 1'b0);
        step();
        check("timeout_one_cycle", bus_if.req_timeout, 1'b0);
        step(2);

        // Acknowledge on the timeout edge wins; hotkey in WAIT_EXIT does not queue.
        bus_if.hotkey = 1'b1;
        expect_ev(EV_MB_RISE, cyc + 1);
        step();
        bus_if.hotkey = 1'b0;
        step();
        frame();
        bus_if.n_int      = 1'b0;
        bus_if.magic_mode = 1'b1;
        expect_ev(EV_MB_FALL, cyc + 1);
        step();
        bus_if.n_int = 1'b1;
        check("ack_beats_timeout", bus_if.req_timeout, 1'b0);
        step();
        bus_if.hotkey = 1'b1;
        step();
        bus_if.hotkey = 1'b0;
        step(3);
        check("wait_exit_no_request", bus_if.magic_button, 1'b0);
        bus_if.magic_mode = 1'b0;
        step(3);
        check("exit_no_request", bus_if.magic_button, 1'b0);
        bus_if.hotkey = 1'b1;
        expect_ev(EV_MB_RISE, cyc + 1);
        step();
        bus_if.hotkey = 1'b0;
        check("idle_after_exit", bus_if.magic_button, 1'b1);
        bus_if.magic_mode = 1'b1;
        expect_ev(EV_MB_FALL, cyc + 1);
        step();
        bus_if.magic_mode = 1'b0;
        step(2);

        // Reset mid-press aborts silently; a fresh press then works normally.
        bus_if.btn_n = 1'b0;
        expect_ev(EV_BP_RISE, cyc + 6);
        step(8);
        frame();
        frame();
        rst_n = 1'b0;
        expect_ev(EV_BP_FALL, cyc + 1);
        step();
        rst_n        = 1'b1;
        bus_if.btn_n = 1'b1;
        check_all_low("mid_press_reset");
        step(10);
        bus_if.btn_n = 1'b0;
        expect_ev(EV_BP_RISE, cyc + 6);
        step(8);
        bus_if.btn_n = 1'b1;
        expect_ev(EV_BP_FALL, cyc + 6);
        expect_ev(EV_MB_RISE, cyc + 7);
        step(8);
        check("post_reset_request", bus_if.magic_button, 1'b1);
        bus_if.magic_mode = 1'b1;
        expect_ev(EV_MB_FALL, cyc + 1);
        step();
        bus_if.magic_mode = 1'b0;
        step(3);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/magic_button_ctrl.md
MAGIC_BUTTON_CTRL -- requirements
Module: magic_button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 140000, clk28 cycles the raw button must stay stable to change its filtered level (5 ms).
REQ-002 Parameter LONG_FRAMES, default 100, frame edges the button must stay held to count as a long press.
REQ-003 Parameter REQ_TIMEOUT_FRAMES, default 10, frame edges allowed for magic_mode to acknowledge a request.
REQ-004 clk28  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low, sampled on clk28.
REQ-006 btn_n  input  1  raw front-panel magic button, asynchronous, low = pressed.
REQ-007 hotkey  input  1  one-cycle keyboard hotkey pulse, clk28-synchronous, equivalent to a short press.
REQ-008 n_int  input  1  frame interrupt, low-active; a frame edge is a 1->0 transition.
REQ-009 magic_mode  input  1  acknowledge from the NMI/magic controller, high while magic mode is active.
REQ-010 magic_button  output  1  request to the magic controller, held high until acknowledged or timed out.
REQ-011 reset_req  output  1  one-cycle pulse on a long press.
REQ-012 req_timeout  output  1  one-cycle pulse when a request expires unacknowledged.
REQ-013 btn_pressed  output  1  debounced, synchronised button level, 1 = pressed.

Function
REQ-014 btn_n passes a 2-flop synchroniser whose flops reset to 1 (released) before any other logic uses it.
REQ-015 Debounce: the counter clears whenever the synchronised level equals btn_pressed; otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1, btn_pressed toggles and the counter clears; the counter is sized for DEBOUNCE_CYCLES with no wrap.
REQ-016 Frame edge detection registers n_int once; frame_edge = previous 1 and current 0; the register resets to 1.
REQ-017 FSM states: IDLE, HELD, LONG, REQUEST, WAIT_EXIT; one frame counter, saturating, cleared on every state entry.
REQ-018 IDLE: magic_mode=1 -> WAIT_EXIT; else a btn_pressed rise -> HELD; else hotkey -> REQUEST; magic_mode takes priority over both.
REQ-019 HELD: a btn_pressed fall before LONG_FRAMES frame edges -> REQUEST (short press acts on release).
REQ-020 HELD: the LONG_FRAMES-th frame edge while pressed -> LONG, with reset_req high for exactly that cycle; no magic request is issued.
REQ-021 LONG: wait for a btn_pressed fall -> IDLE; no further reset_req pulse, however long the button is held.
REQ-022 REQUEST: magic_button=1, registered, asserted the cycle after entry.
REQ-023 REQUEST: magic_mode=1 -> WAIT_EXIT.
REQ-024 REQUEST: the REQ_TIMEOUT_FRAMES-th frame edge without acknowledge -> IDLE, with req_timeout high for one cycle.
REQ-025 REQUEST: if acknowledge and timeout occur in the same cycle, the acknowledge wins and no req_timeout pulse is issued.
REQ-026 WAIT_EXIT: magic_button=0; stay until magic_mode=0, then -> IDLE.
REQ-027 WAIT_EXIT: button presses and hotkey are ignored; a press still held on exit is not acted on until released and pressed again (IDLE needs a fresh rise).
REQ-028 hotkey is ignored in HELD, LONG, REQUEST and WAIT_EXIT; it never queues.
REQ-029 magic_button is 0 in every state except REQUEST; reset_req and req_timeout are never high for more than one consecutive cycle.

Reset
REQ-030 On rst_n=0 at a clk28 edge: state -> IDLE; all counters -> 0; synchroniser and btn_pressed -> released; magic_button, reset_req and req_timeout -> 0.
REQ-031 Reset asserted mid-request or mid-press aborts the operation without emitting any pulse; after release, a button held through reset needs a fresh debounced rise to act.

Verification (bench parameters DEBOUNCE_CYCLES=4, LONG_FRAMES=3, REQ_TIMEOUT_FRAMES=2)
REQ-032 Bounce btn_n low for 2 cycles, high for 1, then low steady -> btn_pressed rises only after 4 stable cycles; release after 1 frame edge -> magic_button=1; drive magic_mode=1 -> magic_button=0 next cycle.
REQ-033 Hold the button across 3 frame edges -> reset_req=1 for exactly 1 cycle on the 3rd edge; magic_button stays 0; hold 5 more edges -> no further pulse.
REQ-034 hotkey pulse in IDLE with magic_mode held 0 -> magic_button=1 from the next cycle; on the 2nd frame edge, req_timeout=1 for 1 cycle and magic_button=0.
REQ-035 In REQUEST, raise magic_mode in the same cycle as the 2nd frame edge -> no req_timeout, state WAIT_EXIT; hotkey during WAIT_EXIT ignored; magic_mode=0 -> IDLE, magic_button stays 0.
REQ-036 Press the button, pull rst_n low for 1 cycle after 2 frame edges while still held -> all outputs 0; release then press again -> normal short-press request.
